// File: rtl/ddr5_adr_ctrl.sv
// ADR initiator: qualifies the PSU power-fail warning, triggers ADR at the PCH and gates PWRGD_FAIL.
// Optional macro ADR_SURPRISE_RESET_EN: a platform reset while armed starts ADR without filtering.
module ddr5_adr_ctrl #(
  parameter int PWRFAIL_FILTER = 4,
  parameter int ADR_TIMEOUT    = 2000,
  parameter int FAIL_HOLD      = 16
) (
  input  logic iClk,
  input  logic iRst_n,
  input  logic iADR_EN,
  input  logic iPWRGD_PS_PWROK,
  input  logic iPWR_FAIL_N,
  input  logic iPLTRST_N,
  input  logic iADR_COMPLETE,
  output logic oFM_ADR_TRIGGER_N,
  output logic oADR_LOGIC,
  output logic oADR_ARMED,
  output logic oADR_DONE,
  output logic oADR_TIMEOUT
);

  localparam int FILT_W  = $clog2(PWRFAIL_FILTER + 1);
  localparam int CYC_MAX = (ADR_TIMEOUT > FAIL_HOLD) ? ADR_TIMEOUT : FAIL_HOLD;
  localparam int CYC_W   = $clog2(CYC_MAX + 1);
  localparam logic [FILT_W-1:0] FILT_MAX  = FILT_W'(PWRFAIL_FILTER);
  localparam logic [CYC_W-1:0]  TO_LAST   = CYC_W'(ADR_TIMEOUT - 1);
  localparam logic [CYC_W-1:0]  HOLD_LAST = CYC_W'(FAIL_HOLD - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARMED = 3'd1,
    ST_WAIT  = 3'd2,
    ST_HOLD  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // Sync bit order: {adr_complete, pltrst_n, pwr_fail_n}; idle levels are the reset values.
  logic [2:0] meta_d, meta_q, sync_d, sync_q;
  logic       s_pwr_fail_n, s_pltrst_n, s_adr_complete;

  state_t              state_d, state_q;
  logic [FILT_W-1:0]   filt_d, filt_q;
  logic [CYC_W-1:0]    cyc_d, cyc_q;
  logic                pf_qual;
  logic                done_d, done_q;
  logic                timeout_d, timeout_q;
  logic                trig_n_d, trig_n_q;
  logic                adr_logic_d, adr_logic_q;
  logic                armed_d, armed_q;

  always_comb begin
    meta_d = {iADR_COMPLETE, iPLTRST_N, iPWR_FAIL_N};
    sync_d = meta_q;
  end

  assign s_pwr_fail_n   = sync_q[0];
  assign s_pltrst_n     = sync_q[1];
  assign s_adr_complete = sync_q[2];

  always_comb begin
    filt_d = filt_q;
    if (s_pwr_fail_n)
      filt_d = '0;
    else if (filt_q != FILT_MAX)
      filt_d = filt_q + FILT_W'(1);
  end

  assign pf_qual = (filt_q == FILT_MAX);

  always_comb begin
    state_d   = state_q;
    done_d    = done_q;
    timeout_d = timeout_q;
    case (state_q)
      ST_IDLE: begin
        if (iPWRGD_PS_PWROK && iADR_EN && s_pltrst_n) begin
          state_d   = ST_ARMED;
          done_d    = 1'b0;
          timeout_d = 1'b0;
        end
      end
      ST_ARMED: begin
        if (!iADR_EN || !iPWRGD_PS_PWROK)
          state_d = ST_IDLE;
        else if (pf_qual)
          state_d = ST_WAIT;
        else if (!s_pltrst_n) begin
`ifdef ADR_SURPRISE_RESET_EN
          if (s_pwr_fail_n)
            state_d = ST_WAIT;
`else
          state_d = ST_IDLE;
`endif
        end
      end
      ST_WAIT: begin
        // Completion is checked first so a same-cycle timeout never flags.
        if (s_adr_complete) begin
          done_d  = 1'b1;
          state_d = ST_HOLD;
        end else if (cyc_q == TO_LAST) begin
          timeout_d = 1'b1;
          state_d   = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (cyc_q == HOLD_LAST)
          state_d = ST_DONE;
      end
      ST_DONE: begin
        if (!iPWRGD_PS_PWROK && !s_pltrst_n)
          state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cyc_d = cyc_q;
    if (state_d != state_q)
      cyc_d = '0;
    else if (state_q == ST_WAIT || state_q == ST_HOLD)
      cyc_d = cyc_q + CYC_W'(1);
  end

  // Outputs decode the next state so they line up with the state register.
  always_comb begin
    trig_n_d    = (state_d != ST_WAIT);
    adr_logic_d = !(state_d == ST_HOLD || state_d == ST_DONE);
    armed_d     = (state_d == ST_ARMED);
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      meta_q      <= 3'b001;
      sync_q      <= 3'b001;
      state_q     <= ST_IDLE;
      filt_q      <= '0;
      cyc_q       <= '0;
      done_q      <= 1'b0;
      timeout_q   <= 1'b0;
      trig_n_q    <= 1'b1;
      adr_logic_q <= 1'b1;
      armed_q     <= 1'b0;
    end else begin
      meta_q      <= meta_d;
      sync_q      <= sync_d;
      state_q     <= state_d;
      filt_q      <= filt_d;
      cyc_q       <= cyc_d;
      done_q      <= done_d;
      timeout_q   <= timeout_d;
      trig_n_q    <= trig_n_d;
      adr_logic_q <= adr_logic_d;
      armed_q     <= armed_d;
    end
  end

  assign oFM_ADR_TRIGGER_N = trig_n_q;
  assign oADR_LOGIC        = adr_logic_q;
  assign oADR_ARMED        = armed_q;
  assign oADR_DONE         = done_q;
  assign oADR_TIMEOUT      = timeout_q;

endmodule

// File: doc/ddr5_adr_ctrl.md
# ddr5_adr_ctrl

Asynchronous DRAM Refresh (ADR) initiator for the DDR5 memory subsystem. Watches the PSU early power-fail warning, triggers ADR at the PCH, and waits for ADR completion or timeout. It then drives `oADR_LOGIC` low so each channel's PWRGD_FAIL block pulls PWRGD_FAIL low and the DIMMs enter self-refresh/save. It sits between the PSU/PCH sideband signals and the per-channel DDR5 PWRGD_FAIL logic, whose `iADR_LOGIC` input it drives.

## Interface
- `PWRFAIL_FILTER`, 4: consecutive cycles the synchronized `iPWR_FAIL_N` must be low to qualify a power failure (≥1).
- `ADR_TIMEOUT`, 2000: maximum cycles in ST_WAIT for ADR completion (≥2).
- `FAIL_HOLD`, 16: cycles spent in ST_HOLD before ST_DONE (≥1).

Ports:
- `iClk`, input, 1: clock. One clock domain.
- `iRst_n`, input, 1: reset, asynchronous, active-low.
- `iADR_EN`, input, 1: ADR feature enable from the BIOS-programmed register. Synchronous.
- `iPWRGD_PS_PWROK`, input, 1: PSU power good. Synchronous.
- `iPWR_FAIL_N`, input, 1: PSU early power-fail warning, active-low. Asynchronous.
- `iPLTRST_N`, input, 1: platform reset. Asynchronous.
- `iADR_COMPLETE`, input, 1: ADR complete from PCH, active-high. Asynchronous.
- `oFM_ADR_TRIGGER_N`, output, 1: ADR trigger to PCH, active-low.
- `oADR_LOGIC`, output, 1: to DDR5 PWRGD_FAIL blocks. 1 releases PWRGD_FAIL; 0 forces it low.
- `oADR_ARMED`, output, 1: high while in ST_ARMED.
- `oADR_DONE`, output, 1: sticky. ADR completed normally.
- `oADR_TIMEOUT`, output, 1: sticky. ADR timed out.

## Operation
- Input synchronizers: `iPWR_FAIL_N`, `iPLTRST_N` and `iADR_COMPLETE` each pass through a 2-FF synchronizer. All FSM decisions use the synchronized versions (`sPWR_FAIL_N`, `sPLTRST_N`, `sADR_COMPLETE`).
- Filter counter:
  - Clears whenever `sPWR_FAIL_N` is 1.
  - Increments while `sPWR_FAIL_N` is 0, saturating at `PWRFAIL_FILTER`.
  - `pf_qual` = (count == `PWRFAIL_FILTER`).
- Cycle counter: width `$clog2(max(ADR_TIMEOUT,FAIL_HOLD)+1)`. Cleared on every state entry. Increments each cycle in ST_WAIT and ST_HOLD.
- ST_IDLE:
  - Go to ST_ARMED when `iPWRGD_PS_PWROK && iADR_EN && sPLTRST_N`.
  - On this transition, clear `oADR_DONE` and `oADR_TIMEOUT`.
- ST_ARMED (`oADR_ARMED`=1):
  - Return to ST_IDLE on `!iADR_EN || !iPWRGD_PS_PWROK`.
  - Otherwise go to ST_WAIT on `pf_qual`.
  - Otherwise, when `sPLTRST_N`=0, behaviour follows the Configuration section.
- ST_WAIT (`oFM_ADR_TRIGGER_N`=0):
  - A drop of `iPWRGD_PS_PWROK` or `iADR_EN` does not abort this state.
  - If `sADR_COMPLETE`=1: set `oADR_DONE`, go to ST_HOLD.
  - Else if counter == `ADR_TIMEOUT-1`: set `oADR_TIMEOUT`, go to ST_HOLD.
  - If completion arrives in the same cycle as the timeout, completion wins and `oADR_TIMEOUT` stays 0.
- ST_HOLD:
  - `oADR_LOGIC`=0 and `oFM_ADR_TRIGGER_N`=1.
  - Go to ST_DONE when counter == `FAIL_HOLD-1`.
- ST_DONE:
  - `oADR_LOGIC` stays 0.
  - Go to ST_IDLE only when `!iPWRGD_PS_PWROK && !sPLTRST_N`, with `oADR_LOGIC` returning to 1.
- Illegal state encoding: go to ST_IDLE.
- All outputs are registered.

## Timing
- Reset values: ST_IDLE; `oFM_ADR_TRIGGER_N`=1, `oADR_LOGIC`=1, `oADR_ARMED`=0, `oADR_DONE`=0, `oADR_TIMEOUT`=0. All counters 0.
- An asynchronous reset in any state immediately restores the reset values, including mid-ADR.
- `iPWR_FAIL_N` falling to `oFM_ADR_TRIGGER_N` low: 2 (sync) + `PWRFAIL_FILTER` + 1 cycles (default 7).
- `sADR_COMPLETE` high to `oADR_LOGIC` low: 1 cycle. `iADR_COMPLETE` pin to `oADR_LOGIC`: 3 cycles.
- Timeout case: trigger low for exactly `ADR_TIMEOUT` cycles.
- `oADR_LOGIC` low for `FAIL_HOLD` cycles in ST_HOLD, then for all of ST_DONE.
- A power-fail glitch shorter than `PWRFAIL_FILTER` synchronized cycles is ignored.

## Configuration
- Macro: `ADR_SURPRISE_RESET_EN`.
- Defined: in ST_ARMED, `sPLTRST_N`=0 with `sPWR_FAIL_N`=1 is a surprise reset. It goes directly to ST_WAIT with no filter and follows the normal ADR flow.
- Not defined: in ST_ARMED, `sPLTRST_N`=0 goes to ST_IDLE with no ADR.
- Either way, the `pf_qual` and disarm checks take priority over the reset check.

## Test plan
- Arm (`iADR_EN`=1, PWROK=1, PLTRST_N=1), then pull `iPWR_FAIL_N` low; raise `iADR_COMPLETE` 50 cycles later -> trigger falls 7 cycles after `iPWR_FAIL_N`; `oADR_LOGIC` falls 3 cycles after complete; `oADR_DONE`=1; ST_DONE reached 16 cycles later.
- Armed, pulse `iPWR_FAIL_N` low for 3 cycles -> no trigger; `oADR_ARMED` stays 1.
- Armed, power fail with `iADR_COMPLETE` never asserted -> trigger low for exactly 2000 cycles; `oADR_TIMEOUT`=1, `oADR_DONE`=0; `oADR_LOGIC`=0.
- Force completion in the same cycle as the timeout -> `oADR_DONE`=1, `oADR_TIMEOUT`=0.
- Armed, drop `iPLTRST_N` with `iPWR_FAIL_N`=1 -> with the macro defined, trigger low 3 cycles later; without it, return to ST_IDLE and `oADR_ARMED`=0.
- Assert `iRst_n` low during ST_WAIT, and separately drop PWROK in ST_WAIT -> reset immediately gives trigger=1, `oADR_LOGIC`=1, all flags 0; the PWROK drop does not abort ST_WAIT.
